image_streamer: RTL and testbench
=================================

IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning image side length in pixels (frame = N*N pixels).
REQ-002 The module SHALL have parameter pixelWidth, default 8, meaning bits per pixel.
REQ-003 The module SHALL have parameter bitSize, default $clog2(N*N), meaning pixel index width; it is derived and never set manually.
REQ-004 The module SHALL have parameter FIFO_DEPTH, default 4, meaning input buffer entries (power of two, >=2).
REQ-005 The module SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port rst, input, 1 bit, meaning reset (asynchronous, active-high).
REQ-007 The module SHALL have port start, input, 1 bit, meaning begin one frame transfer (sampled in IDLE only).
REQ-008 The module SHALL have port s_valid, input, 1 bit, meaning upstream pixel valid.
REQ-009 The module SHALL have port s_data, input, pixelWidth bits, meaning upstream pixel.
REQ-010 The module SHALL have port s_ready, output, 1 bit, meaning the FIFO can accept a pixel.
REQ-011 The module SHALL have port we, output, 1 bit, meaning write enable to mainController.
REQ-012 The module SHALL have port data_out, output, pixelWidth bits, meaning pixel to mainController data_in.
REQ-013 The module SHALL have port pixel_idx, output, bitSize bits, meaning index of the pixel currently presented.
REQ-014 The module SHALL have port busy, output, 1 bit, meaning high while in LOAD.
REQ-015 The module SHALL have port frame_done, output, 1 bit, meaning one-cycle pulse after the last pixel is presented.
REQ-016 The module SHALL have port stall_cnt, output, 16 bits, meaning count of slot boundaries with an empty FIFO during the current frame (saturating).

Function
REQ-017 A pixel SHALL be accepted when s_valid && s_ready, in any state; s_ready SHALL equal !full, with no combinational dependence on pop.
REQ-018 Push and pop in the same cycle SHALL leave the occupancy unchanged; there SHALL be no empty-FIFO bypass.
REQ-019 The FSM SHALL have states IDLE, LOAD and DONE; IDLE->LOAD on start; LOAD->DONE after pixel N*N-1 completes its slot; DONE->IDLE unconditionally after one cycle.
REQ-020 In LOAD, each pixel SHALL be presented for exactly 2 consecutive cycles with we=1 and data_out/pixel_idx stable (slot phase 0, then phase 1).
REQ-021 At a slot boundary, a pop SHALL occur if the FIFO is non-empty, and the slot SHALL begin next cycle; if the FIFO is empty, we SHALL be 0, the phase SHALL hold, and stall_cnt SHALL increment.
REQ-022 Latency: with start at cycle t and the FIFO non-empty, we=1 with pixel 0 SHALL appear at cycle t+1; an unstalled frame SHALL hold we high for 2*N*N consecutive cycles.
REQ-023 pixel_idx SHALL increment once per slot and SHALL wrap to 0 on LOAD exit.
REQ-024 frame_done SHALL be high only in DONE; we SHALL be 0 in IDLE and DONE.
REQ-025 start SHALL be ignored in LOAD and DONE, and stall_cnt SHALL clear on IDLE->LOAD.
REQ-026 Pixels beyond N*N SHALL remain in the FIFO for the next frame.

Reset
REQ-027 When rst is asserted, the module SHALL asynchronously enter IDLE, flush the FIFO, and drive we=0, data_out=0, pixel_idx=0, busy=0, frame_done=0 and stall_cnt=0; s_ready SHALL be 1 on the first cycle after release.
REQ-028 Reset asserted mid-frame SHALL abort the transfer with no frame_done; the pixels already sent SHALL NOT be resumed.

Structure
REQ-029 The state enum and the default slot length (2 cycles) SHALL reside in shared package harris_pkg.
REQ-030 The buffer SHALL be sub-module pixel_fifo (parameters pixelWidth and FIFO_DEPTH; ports push/pop/full/empty/count).

Verification
REQ-031 The bench SHALL cover: N=8, 64 pixels preloaded at pixelWidth=8 with values 0..63, then start -> we high for 128 cycles, data_out=k in cycles 2k+1 and 2k+2, one frame_done pulse, stall_cnt=0.
REQ-032 The bench SHALL cover: with the FIFO empty and start issued, then one pixel fed every 5 cycles -> we low between slots, stall_cnt>0, and all 64 values delivered in order.
REQ-033 The bench SHALL cover: s_valid held high with no start -> exactly 4 pixels accepted, s_ready=0, we=0.
REQ-034 The bench SHALL cover: rst pulsed at pixel 20 -> we=0 immediately, no frame_done, and FIFO empty after release.
REQ-035 The bench SHALL cover: start pulsed during LOAD -> no effect on pixel_idx or frame length.
REQ-036 The bench SHALL cover: 70 pixels supplied across two frames -> pixels 64..69 open frame 2 as idx 0..5.

Source files
------------

// File: rtl/harris_pkg.sv
// Shared definitions for the image streaming path: controller states and slot timing.
package harris_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of consecutive cycles each pixel is presented to the main controller.
  localparam int unsigned SLOT_LEN = 2;

endpackage

// File: rtl/pixel_fifo.sv
// Small power-of-two input buffer; push is ignored when full, pop is ignored when empty.
module pixel_fifo #(
  parameter int pixelWidth = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [pixelWidth-1:0] din,
  output logic [pixelWidth-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
);
  import harris_pkg::*;

  localparam int CW = AW + 1;

  logic [pixelWidth-1:0] mem_q [FIFO_DEPTH];
  logic [pixelWidth-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next storage, pointer and occupancy values for this cycle's push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Buffer state registers; reset flushes the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/image_streamer.sv
// Streams one N*N frame of buffered pixels to the main controller, two cycles per pixel.
module image_streamer #(
  parameter int N          = 8,
  parameter int pixelWidth = 8,
  parameter int bitSize    = $clog2(N * N),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [pixelWidth-1:0] s_data,
  output logic                  s_ready,
  output logic                  we,
  output logic [pixelWidth-1:0] data_out,
  output logic [bitSize-1:0]    pixel_idx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           stall_cnt
);
  import harris_pkg::*;

  localparam int unsigned PHASE_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SLOT_LEN - 1);
  localparam logic [bitSize-1:0] LAST_IDX   = bitSize'(N * N - 1);

  logic [pixelWidth-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [pixelWidth-1:0] data_out_q, data_out_d;
  logic [bitSize-1:0]    pixel_idx_q, pixel_idx_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  // Acceptance depends only on occupancy, never on this cycle's pop.
  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && !fifo_full;

  pixel_fifo #(
    .pixelWidth (pixelWidth),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign we         = we_q;
  assign data_out   = data_out_q;
  assign pixel_idx  = pixel_idx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign stall_cnt  = stall_cnt_q;

  // Next controller state: slot sequencing, boundary pops and stall accounting.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    data_out_d   = data_out_q;
    pixel_idx_d  = pixel_idx_q;
    phase_d      = phase_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    stall_cnt_d  = stall_cnt_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          busy_d      = 1'b1;
          stall_cnt_d = '0;
          pixel_idx_d = '0;
          phase_d     = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            we_d       = 1'b1;
            data_out_d = fifo_dout;
          end else begin
            we_d = 1'b0;
          end
        end
      end
      LOAD: begin
        if (we_q && (phase_q != LAST_PHASE)) begin
          phase_d = phase_q + PHASE_W'(1);
        end else if (we_q && (pixel_idx_q == LAST_IDX)) begin
          state_d      = DONE;
          we_d         = 1'b0;
          frame_done_d = 1'b1;
          pixel_idx_d  = '0;
          phase_d      = '0;
          busy_d       = 1'b0;
        end else begin
          // The index advances when a slot ends, so a stall shows the upcoming index.
          if (we_q) begin
            pixel_idx_d = pixel_idx_q + bitSize'(1);
          end
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            we_d       = 1'b1;
            data_out_d = fifo_dout;
            phase_d    = '0;
          end else begin
            we_d = 1'b0;
            if (stall_cnt_q != '1) begin
              stall_cnt_d = stall_cnt_q + 16'd1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      data_out_q   <= '0;
      pixel_idx_q  <= '0;
      phase_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      data_out_q   <= data_out_d;
      pixel_idx_q  <= pixel_idx_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  a_fifo_empty_consistent : assert property (@(posedge clk) disable iff (rst)
    fifo_empty == (fifo_count == '0));
  a_fifo_full_consistent : assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_image_streamer.sv
// Bench for image_streamer: vector table, frame scenarios and randomized traffic against a queue model.
module tb_image_streamer;

  localparam int N    = 8;
  localparam int PW   = 8;
  localparam int FD   = 4;
  localparam int NPIX = N * N;
  localparam int BS   = $clog2(NPIX);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [PW-1:0] s_data = '0;
  logic          s_ready;
  logic          we;
  logic [PW-1:0] data_out;
  logic [BS-1:0] pixel_idx;
  logic          busy;
  logic          frame_done;
  logic [15:0]   stall_cnt;

  image_streamer #(
    .N          (N),
    .pixelWidth (PW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .we         (we),
    .data_out   (data_out),
    .pixel_idx  (pixel_idx),
    .busy       (busy),
    .frame_done (frame_done),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue for the buffer plus frame-level counters.
  logic [PW-1:0] m_fifo[$];
  int            m_mode  = 0;   // 0 idle, 1 streaming, 2 done
  int            m_left  = 0;   // cycles left in the current slot
  int            m_idx   = 0;
  int            m_stall = 0;
  logic          m_we    = 1'b0;
  logic          m_fd    = 1'b0;
  logic          m_busy  = 1'b0;
  logic [PW-1:0] m_data  = '0;
  bit            m_acc   = 1'b0;

  task automatic model_step();
    bit have;
    if (rst) begin
      m_fifo.delete();
      m_mode = 0; m_left = 0; m_idx = 0; m_stall = 0;
      m_we = 1'b0; m_fd = 1'b0; m_busy = 1'b0; m_data = '0; m_acc = 1'b0;
      return;
    end
    m_acc = s_valid && (m_fifo.size() < FD);
    have  = (m_fifo.size() > 0);
    m_fd  = 1'b0;
    case (m_mode)
      0: if (start) begin
        m_mode = 1; m_busy = 1'b1; m_stall = 0; m_idx = 0;
        if (have) begin m_data = m_fifo.pop_front(); m_we = 1'b1; m_left = 2; end
        else m_we = 1'b0;
      end
      1: begin
        if (m_we && m_left > 1) m_left--;
        else if (m_we && m_idx == NPIX - 1) begin
          m_mode = 2; m_we = 1'b0; m_fd = 1'b1; m_idx = 0; m_busy = 1'b0;
        end else begin
          if (m_we) m_idx++;
          if (have) begin m_data = m_fifo.pop_front(); m_we = 1'b1; m_left = 2; end
          else begin m_we = 1'b0; if (m_stall < 65535) m_stall++; end
        end
      end
      default: m_mode = 0;
    endcase
    if (m_acc) m_fifo.push_back(s_data);
  endtask

  // Feeder: 0 manual, 1 continuous up to a limit, 2 one pixel every 5 cycles, 3 random.
  int feed_mode  = 0;
  int feed_next  = 0;
  int feed_limit = 0;
  int feed_gap   = 0;

  task automatic tick();
    logic [63:0] act, exp;
    @(posedge clk);
    model_step();
    if (m_acc && (feed_mode == 1 || feed_mode == 2)) begin
      feed_next++;
      feed_gap = 5;
    end
    @(negedge clk);
    cyc_n++;
    act = {30'd0, s_ready, we, busy, frame_done, data_out, pixel_idx, stall_cnt};
    exp = {30'd0, (m_fifo.size() < FD), m_we, m_busy, m_fd, m_data, m_idx[BS-1:0], m_stall[15:0]};
    check($sformatf("model_cycle%0d", cyc_n), act, exp);
    case (feed_mode)
      1: begin s_valid = (feed_next < feed_limit); s_data = feed_next[PW-1:0]; end
      2: begin
        if (feed_gap > 0) feed_gap--;
        s_valid = (feed_gap == 0) && (feed_next < feed_limit);
        s_data  = feed_next[PW-1:0];
      end
      3: begin s_valid = 1'($urandom_range(0, 1)); s_data = PW'($urandom_range(0, 255)); end
      default: ;
    endcase
  endtask

  task automatic reset_dut();
    feed_mode = 0; s_valid = 1'b0; start = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic preload_and_start(input int limit);
    feed_mode = 1; feed_next = 0; feed_limit = limit;
    s_valid = 1'b1; s_data = '0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full unstalled frame: pixel k presented for exactly two cycles, then one done pulse.
  task automatic run_frame(input int limit, input bit poke, input string tag);
    int we_cnt, bad, fd_cnt;
    preload_and_start(limit);
    we_cnt = 0; bad = 0; fd_cnt = 0;
    for (int k = 0; k < 2 * NPIX; k++) begin
      if (we) we_cnt++;
      if (data_out !== PW'(k / 2) || pixel_idx !== BS'(k / 2)) bad++;
      if (frame_done) fd_cnt++;
      if (poke && (k % 37 == 5)) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check({tag, "_done_pulse"}, frame_done, 1);
    check({tag, "_we_low_done"}, we, 0);
    check({tag, "_stall_zero"}, stall_cnt, 0);
    check({tag, "_idx_wrap"}, pixel_idx, 0);
    if (frame_done) fd_cnt++;
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_idle_after_done"}, busy, 0);
    check({tag, "_done_one_cycle"}, frame_done, 0);
    if (frame_done) fd_cnt++;
    check({tag, "_we_cycles"}, we_cnt, 2 * NPIX);
    check({tag, "_slot_data_bad"}, bad, 0);
    check({tag, "_done_count"}, fd_cnt, 1);
  endtask

  typedef struct {
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [PW-1:0] s_data;
    logic          exp_ready;
    logic          exp_we;
    logic          exp_busy;
    logic [PW-1:0] exp_data;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int n, gaps, bad, slots, fd_seen;
    logic          prev_we;
    logic [BS-1:0] prev_idx;
    logic [PW-1:0] got[$];

    // rst, start, s_valid, s_data -> s_ready, we, busy, data_out
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h13};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; start = tbl[i].start;
      s_valid = tbl[i].s_valid; s_data = tbl[i].s_data;
      tick();
      check($sformatf("vec%0d_ready", i), s_ready, tbl[i].exp_ready);
      check($sformatf("vec%0d_we", i), we, tbl[i].exp_we);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
      check($sformatf("vec%0d_data", i), data_out, tbl[i].exp_data);
    end
    rst = 1'b0; start = 1'b0; s_valid = 1'b0;
    tick();
    check("reset_state", {s_ready, we, busy, frame_done, data_out, pixel_idx, stall_cnt},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 16'd0});

    // Continuously fed frame of values 0..63.
    reset_dut();
    run_frame(64, 1'b0, "frame");

    // Start pulses inside the frame and in the done cycle change nothing.
    reset_dut();
    run_frame(64, 1'b1, "poke");

    // Starved frame: one pixel every 5 cycles.
    reset_dut();
    feed_mode = 2; feed_next = 0; feed_limit = NPIX; feed_gap = 5; s_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("starve_first_we", we, 0);
    got.delete(); gaps = 0; n = 0; prev_we = 1'b0; prev_idx = '0;
    while (!frame_done && n < 2000) begin
      if (we && (!prev_we || pixel_idx != prev_idx)) got.push_back(data_out);
      if (busy && !we) gaps++;
      prev_we = we; prev_idx = pixel_idx;
      tick();
      n++;
    end
    check("starve_done_seen", frame_done, 1);
    check("starve_pixel_count", got.size(), NPIX);
    bad = 0;
    foreach (got[i]) if (got[i] !== PW'(i)) bad++;
    check("starve_order_bad", bad, 0);
    check("starve_gaps_nonzero", (gaps > 0), 1);
    check("starve_stall_nonzero", (stall_cnt != 16'd0), 1);

    // Reset in the middle of a frame.
    reset_dut();
    preload_and_start(NPIX);
    fd_seen = 0; n = 0;
    while (!(we && pixel_idx == BS'(20)) && n < 200) begin
      if (frame_done) fd_seen++;
      tick();
      n++;
    end
    check("abort_reached_px20", pixel_idx, 20);
    feed_mode = 0; s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_we_async", we, 0);
    check("abort_busy_async", busy, 0);
    check("abort_idx_async", pixel_idx, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    if (frame_done) fd_seen++;
    check("abort_ready_after", s_ready, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      if (frame_done) fd_seen++;
      tick();
    end
    check("abort_fifo_empty_we", we, 0);
    check("abort_fifo_empty_stall", (stall_cnt != 16'd0), 1);
    check("abort_no_done", fd_seen, 0);

    // 70 pixels: 64..69 open the second frame as indices 0..5.
    reset_dut();
    run_frame(70, 1'b0, "two");
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    slots = 0; n = 0; prev_we = 1'b0; prev_idx = '0;
    while (slots < 6 && n < 40) begin
      if (we && (!prev_we || pixel_idx != prev_idx)) begin
        check($sformatf("f2_slot%0d_data", slots), data_out, 64 + slots);
        check($sformatf("f2_slot%0d_idx", slots), pixel_idx, slots);
        slots++;
      end
      prev_we = we; prev_idx = pixel_idx;
      tick();
      n++;
    end
    check("f2_slots_seen", slots, 6);

    // Random traffic, random start pulses and rare resets.
    reset_dut();
    feed_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; feed_mode = 0; s_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
